// File: rtl/imem_loader_if.sv
// Byte-stream load port plus the core's fetch port for imem_loader.
//   in_valid / in_ready / in_data : byte stream handshake (master drives valid/data)
//   rd_addr / rd_data             : word-addressed fetch port, rd_data combinational
interface imem_loader_if #(
    parameter int unsigned AW = 8
) ();

    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;

    // Stream source / fetching core side
    modport master (
        output in_valid,
        output in_data,
        output rd_addr,
        input  in_ready,
        input  rd_data
    );

    // Loader side
    modport slave (
        input  in_valid,
        input  in_data,
        input  rd_addr,
        output in_ready,
        output rd_data
    );

endinterface

// File: rtl/imem_loader.sv
// Instruction memory writer: parses a length-prefixed, XOR-checksummed byte
// stream into a DEPTH x 32 RAM and holds the core in reset until the image
// has been fully written and its checksum verified.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   bus           imem_loader_if.slave: byte stream in, fetch port out
//   cpu_reset     high until a load completes successfully
//   load_done     image written and checksum matched
//   load_err      load aborted on oversize length or bad checksum
//   words_loaded  words written to RAM by the current load
//
// Stream: LEN_HI LEN_LO, then 4*N big-endian data bytes, then one byte equal
// to the XOR of all preceding bytes.
module imem_loader #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   words_loaded
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_e;

    state_e        state_q,     state_d;
    logic [7:0]    len_hi_q,    len_hi_d;
    logic [CW-1:0] len_q,       len_d;
    logic [CW-1:0] words_q,     words_d;
    logic [1:0]    bcnt_q,      bcnt_d;
    logic [23:0]   asm_q,       asm_d;
    logic [7:0]    csum_q,      csum_d;
    logic          in_ready_q,  in_ready_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          load_done_q, load_done_d;
    logic          load_err_q,  load_err_d;

    logic          accept;
    logic [15:0]   len_full;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;

    logic [31:0]   mem [DEPTH];

    assign accept   = bus.in_valid && in_ready_q;
    assign len_full = {len_hi_q, bus.in_data};

    // Stream parser: next state, datapath updates and RAM write strobe
    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        words_d  = words_q;
        bcnt_d   = bcnt_q;
        asm_d    = asm_q;
        csum_d   = csum_q;
        we       = 1'b0;
        waddr    = words_q[AW-1:0];
        // Only the previous three bytes are held; the fourth arrives on the bus.
        wdata    = {asm_q, bus.in_data};

        if (accept) begin
            case (state_q)
                ST_LEN_HI: begin
                    len_hi_d = bus.in_data;
                    csum_d   = csum_q ^ bus.in_data;
                    state_d  = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    csum_d = csum_q ^ bus.in_data;
                    if (len_full == 16'd0) begin
                        state_d = ST_CSUM;
                    end else if (32'(len_full) > DEPTH) begin
                        state_d = ST_ERROR;
                    end else begin
                        len_d   = CW'(len_full);
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    csum_d = csum_q ^ bus.in_data;
                    asm_d  = {asm_q[15:0], bus.in_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we      = 1'b1;
                        words_d = words_q + CW'(1);
                        if (words_q + CW'(1) == len_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (bus.in_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                default: ;
            endcase
        end

        // Status flags follow the next state so they appear with it
        in_ready_d  = (state_d != ST_DONE) && (state_d != ST_ERROR);
        cpu_reset_d = (state_d != ST_DONE);
        load_done_d = (state_d == ST_DONE);
        load_err_d  = (state_d == ST_ERROR);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LEN_HI;
            len_hi_q    <= 8'd0;
            len_q       <= '0;
            words_q     <= '0;
            bcnt_q      <= 2'd0;
            asm_q       <= 24'd0;
            csum_q      <= 8'd0;
            in_ready_q  <= 1'b1;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            words_q     <= words_d;
            bcnt_q      <= bcnt_d;
            asm_q       <= asm_d;
            csum_q      <= csum_d;
            in_ready_q  <= in_ready_d;
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    // Word RAM; contents survive reset, but reset blocks a write on its edge
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[waddr] <= wdata;
        end
    end

    // Fetch port: asynchronous read, no write bypass
    assign bus.rd_data  = mem[bus.rd_addr];
    assign bus.in_ready = in_ready_q;

    assign cpu_reset    = cpu_reset_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed and random streams, a
// stream-level reference model, and a monitor that checks each load outcome.
module tb_imem_loader;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_reset;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;

    always #5 clk = ~clk;

    imem_loader_if #(.AW(AW)) bus ();

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    typedef bit [7:0] bq_t[$];
    typedef struct {
        bit done;
        bit err;
        int words;
    } exp_t;

    exp_t      exp_q[$];
    int        checks = 0;
    int        errors = 0;
    bit [31:0] model_mem   [DEPTH];
    bit        model_valid [DEPTH];
    bit        mon_armed = 1'b1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference model: interprets the whole stream by its format rules.
    // Writes completed words into model_mem, reports the outcome (if the
    // stream reaches one) and how many bytes the loader should accept.
    task automatic model_run(input bq_t s, output bit has_out, output exp_t e,
                             output int consumed);
        int        n;
        int        total;
        bit [7:0]  x;
        has_out  = 1'b0;
        e        = '{done: 1'b0, err: 1'b0, words: 0};
        consumed = s.size();
        if (s.size() < 2) return;
        n = int'({s[0], s[1]});
        if (n > int'(DEPTH)) begin
            has_out  = 1'b1;
            e.err    = 1'b1;
            consumed = 2;
            return;
        end
        for (int w = 0; w < n; w++) begin
            if (s.size() >= 2 + 4 * w + 4) begin
                model_mem[w]   = {s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]};
                model_valid[w] = 1'b1;
            end
        end
        total = 2 + 4 * n + 1;
        if (s.size() < total) return;
        consumed = total;
        x = 8'd0;
        for (int i = 0; i < total - 1; i++) x ^= s[i];
        has_out = 1'b1;
        e.done  = (s[total-1] == x);
        e.err   = !e.done;
        e.words = n;
    endtask

    // Drives every byte of s; bytes offered while in_ready is low are not counted
    task automatic send(input bq_t s, input int gap_mode, output int acc);
        int g;
        acc = 0;
        foreach (s[i]) begin
            g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 3));
            if (i > 0) begin
                repeat (g) begin
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                    bus.in_data  = 8'($urandom);
                end
            end
            @(negedge clk);
            if (bus.in_ready) acc++;
            bus.in_valid = 1'b1;
            bus.in_data  = s[i];
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic ram_readback();
        for (int a = 0; a < int'(DEPTH); a++) begin
            if (model_valid[a]) begin
                bus.rd_addr = AW'(a);
                #1;
                check($sformatf("ram[%0d]", a), bus.rd_data, model_mem[a]);
            end
        end
    endtask

    task automatic run_load(input bq_t s, input int gap_mode);
        bit   has;
        exp_t e;
        int   cons;
        int   acc;
        model_run(s, has, e, cons);
        if (has) exp_q.push_back(e);
        send(s, gap_mode, acc);
        check("accepted_bytes", acc, cons);
        if (has) begin
            check("end_done", load_done, e.done);
            check("end_err", load_err, e.err);
        end
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("outcome_seen", 0, 1);
            exp_q.delete();
        end
        ram_readback();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_words", words_loaded, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        check("rst_in_ready", bus.in_ready, 1);
    endtask

    // Monitor: one outcome per load, compared against the scoreboard head
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!load_done && !load_err) begin
                mon_armed = 1'b1;
            end else if (mon_armed) begin
                exp_t e;
                mon_armed = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_outcome", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_done", load_done, e.done);
                    check("mon_err", load_err, e.err);
                    check("mon_words", words_loaded, e.words);
                    check("mon_cpu_reset", cpu_reset, !e.done);
                    check("mon_in_ready", bus.in_ready, 0);
                end
            end
        end
    end

    initial begin
        bq_t  s2;
        bq_t  s;
        int   n;
        bit [7:0] x;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        bus.rd_addr  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("init_words", words_loaded, 0);
        check("init_cpu_reset", cpu_reset, 1);
        check("init_done", load_done, 0);
        check("init_err", load_err, 0);
        check("init_in_ready", bus.in_ready, 1);

        s2 = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'hAC, 8'h02, 8'h00, 8'h54, 8'hDF};

        // Two-word image, back to back
        run_load(s2, 0);
        bus.rd_addr = 8'd0; #1; check("ram0_const", bus.rd_data, 32'h20020005);
        bus.rd_addr = 8'd1; #1; check("ram1_const", bus.rd_data, 32'hAC020054);
        do_reset();

        // Same image with two idle cycles between bytes
        run_load(s2, 1);
        do_reset();

        // Bad checksum, with trailing bytes that must be ignored
        s = s2;
        s[10] = 8'hDE;
        s.push_back(8'h11);
        s.push_back(8'h22);
        run_load(s, 0);
        do_reset();

        // Zero length
        s = '{8'h00, 8'h00, 8'h00};
        run_load(s, 0);
        do_reset();

        // Oversize length
        s = '{8'h01, 8'h01, 8'h20, 8'h02, 8'h00};
        run_load(s, 0);
        do_reset();

        // Reset after six bytes, then the full image again
        s = s2[0:5];
        run_load(s, 0);
        do_reset();
        run_load(s2, 0);
        do_reset();

        // Full RAM
        s = '{8'h01, 8'h00};
        for (int i = 0; i < 4 * int'(DEPTH); i++) s.push_back(8'($urandom));
        x = 8'd0;
        foreach (s[i]) x ^= s[i];
        s.push_back(x);
        run_load(s, 2);
        do_reset();

        // Random images: lengths, corruption, gaps, junk and truncation
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 5))
                0:       n = 0;
                4:       n = int'($urandom_range(240, DEPTH));
                5:       n = int'($urandom_range(DEPTH + 1, 65535));
                default: n = int'($urandom_range(1, 12));
            endcase
            s = {};
            s.push_back(n[15:8]);
            s.push_back(n[7:0]);
            if (n <= int'(DEPTH)) begin
                for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
                x = 8'd0;
                foreach (s[i]) x ^= s[i];
                if ($urandom_range(0, 3) == 0) x ^= 8'(8'd1 << $urandom_range(0, 7));
                s.push_back(x);
            end
            repeat ($urandom_range(0, 3)) s.push_back(8'($urandom));
            if ($urandom_range(0, 5) == 0) begin
                s = s[0:$urandom_range(0, s.size() - 1)];
            end
            run_load(s, int'($urandom_range(0, 2)));
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
